// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline hold/flush sequencer for load-use, branch, mul/div and memory waits; optional perf counters via HAZARD_PERF_COUNTERS_EN
module hazard_stall_controller #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_RD,
  input  logic        EX_MEM_READ,
  input  logic        EX_MULDIV,
  input  logic        EX_BRANCH_TAKEN,
  input  logic        IMEM_BUSYWAIT,
  input  logic        DMEM_BUSYWAIT,
  output logic        PC_HOLD,
  output logic        IF_ID_HOLD,
  output logic        ID_EX_HOLD,
  output logic        EX_MEM_HOLD,
  output logic        MEM_WB_HOLD,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_FLUSH,
  output logic        MULDIV_BUSY,
  output logic [31:0] STALL_CYCLES,
  output logic [31:0] FLUSH_COUNT
);
  typedef enum logic {RUN, MULDIV} state_t;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mem_wait, hazard, branch, md_stall, load_use, live;
  logic trig, dec, rel;
  // classify this cycle's hazard by priority: memory wait, branch, mul/div, load-use
  always_comb begin
    live = !RESET;
    mem_wait = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
    hazard = EX_MEM_READ && (EX_RD != 5'd0) &&
             ((ID_USES_RS1 && (ID_RS1 == EX_RD)) || (ID_USES_RS2 && (ID_RS2 == EX_RD)));
    branch = !mem_wait && (state_q == RUN) && EX_BRANCH_TAKEN;
    md_stall = !mem_wait && !branch && ((state_q == MULDIV) ? (cnt_q != '0) : EX_MULDIV);
    load_use = !mem_wait && (state_q == RUN) && !EX_BRANCH_TAKEN && !EX_MULDIV && hazard;
  end
  // drive holds and flushes; everything is forced low while reset is asserted
  always_comb begin
    PC_HOLD = live & (mem_wait | md_stall | load_use);
    IF_ID_HOLD = live & (mem_wait | md_stall | load_use);
    ID_EX_HOLD = live & (mem_wait | md_stall);
    EX_MEM_HOLD = live & mem_wait;
    MEM_WB_HOLD = live & mem_wait;
    IF_ID_FLUSH = live & branch;
    ID_EX_FLUSH = live & (branch | load_use);
    EX_MEM_FLUSH = live & md_stall;
    MULDIV_BUSY = live & (state_q == MULDIV);
  end
  // countdown keeps running during memory waits since the mul/div unit is independent
  always_comb begin
    trig = (state_q == RUN) && !mem_wait && !EX_BRANCH_TAKEN && EX_MULDIV;
    dec = (state_q == MULDIV) && (cnt_q != '0);
    rel = (state_q == MULDIV) && !mem_wait && (cnt_q == '0);
    cnt_d = trig ? CNT_LOAD : dec ? cnt_q - CNT_ONE : cnt_q;
    state_d = trig ? MULDIV : rel ? RUN : state_q;
  end
  // FSM state and countdown register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_q, stall_d, flush_q, flush_d;
  // saturating event counters
  always_comb begin
    stall_d = (PC_HOLD && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;
    flush_d = ((IF_ID_FLUSH | ID_EX_FLUSH) && (flush_q != 32'hFFFF_FFFF)) ? flush_q + 32'd1 : flush_q;
  end
  // counter registers, cleared by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign STALL_CYCLES = RESET ? 32'd0 : stall_q;
  assign FLUSH_COUNT = RESET ? 32'd0 : flush_q;
`else
  assign STALL_CYCLES = 32'd0;
  assign FLUSH_COUNT = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: randomized + directed scoreboard bench against a cycle-count reference model
module tb_hazard_stall_controller;
  localparam int N = 5;
  typedef struct packed {
    logic rst;
    logic [4:0] r1, r2, rd;
    logic u1, u2, mr, md, br, iw, dw;
  } in_t;
  typedef struct packed {
    logic [8:0] ctrl;
    logic [31:0] stall, flush;
  } exp_t;
  logic clk = 0;
  in_t s;
  logic pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold;
  logic if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy;
  logic [31:0] stall_cycles, flush_count;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit active = 0;
  int t0 = 0, cyc = 0;
  logic [31:0] m_stall = 0, m_flush = 0;
  always #5 clk = ~clk;
  hazard_stall_controller #(.MULDIV_CYCLES(N), .CNT_W(8)) dut (
    .CLK(clk), .RESET(s.rst), .ID_RS1(s.r1), .ID_RS2(s.r2),
    .ID_USES_RS1(s.u1), .ID_USES_RS2(s.u2), .EX_RD(s.rd),
    .EX_MEM_READ(s.mr), .EX_MULDIV(s.md), .EX_BRANCH_TAKEN(s.br),
    .IMEM_BUSYWAIT(s.iw), .DMEM_BUSYWAIT(s.dw),
    .PC_HOLD(pc_hold), .IF_ID_HOLD(if_id_hold), .ID_EX_HOLD(id_ex_hold),
    .EX_MEM_HOLD(ex_mem_hold), .MEM_WB_HOLD(mem_wb_hold),
    .IF_ID_FLUSH(if_id_flush), .ID_EX_FLUSH(id_ex_flush), .EX_MEM_FLUSH(ex_mem_flush),
    .MULDIV_BUSY(muldiv_busy), .STALL_CYCLES(stall_cycles), .FLUSH_COUNT(flush_count)
  );
  // ctrl bit order: pc, if_id_h, id_ex_h, ex_mem_h, mem_wb_h, if_id_f, id_ex_f, ex_mem_f, busy
  task automatic step(input in_t v);
    exp_t e;
    bit mw, lu, stall, hold_all, fl_br, fl_lu;
    @(posedge clk);
    #1;
    s = v;
    e = '0;
    mw = v.iw | v.dw;
    lu = v.mr && v.rd != 0 && ((v.u1 && v.r1 == v.rd) || (v.u2 && v.r2 == v.rd));
    stall = 0; hold_all = 0; fl_br = 0; fl_lu = 0;
    if (!v.rst) begin
      if (mw) hold_all = 1;
      else if (!active && v.br) fl_br = 1;
      else if (active) stall = (cyc < t0 + N);
      else if (v.md) stall = 1;
      else if (lu) fl_lu = 1;
      e.ctrl = {hold_all | stall | fl_lu, hold_all | stall | fl_lu, hold_all | stall,
                hold_all, hold_all, fl_br, fl_br | fl_lu, stall, active};
`ifdef HAZARD_PERF_COUNTERS_EN
      e.stall = m_stall;
      e.flush = m_flush;
`endif
    end
    q.push_back(e);
    if (v.rst) begin
      active = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e.ctrl[8] && m_stall != 32'hFFFF_FFFF) m_stall++;
      if ((fl_br | fl_lu) && m_flush != 32'hFFFF_FFFF) m_flush++;
      if (!mw && !active && !v.br && v.md) begin active = 1; t0 = cyc; end
      else if (active && !mw && cyc >= t0 + N) active = 0;
    end
    cyc++;
  endtask
  // monitor: compare whatever the stimulus side expects for this cycle
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act;
    if (q.size() != 0) begin
      e = q.pop_front();
      act = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold,
             if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy};
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl t=%0t got=%b exp=%b", $time, act, e.ctrl);
      end
      checks++;
      if (stall_cycles !== e.stall) begin
        errors++;
        $display("FAIL stall_cycles t=%0t got=%0d exp=%0d", $time, stall_cycles, e.stall);
      end
      checks++;
      if (flush_count !== e.flush) begin
        errors++;
        $display("FAIL flush_count t=%0t got=%0d exp=%0d", $time, flush_count, e.flush);
      end
    end
  end
  initial begin
    in_t v;
    s = '0;
    s.rst = 1;
    v = '0; v.rst = 1;
    step(v); step(v);
    v = '0; v.mr = 1; v.rd = 5; v.r2 = 5; v.u2 = 1;
    step(v);
    v = '0; step(v);
    v.mr = 1; v.rd = 0; v.r2 = 0; v.u2 = 1;
    step(v);
    v = '0; v.md = 1;
    repeat (N + 1) step(v);
    v = '0; step(v);
    v = '0; v.br = 1; v.mr = 1; v.rd = 7; v.r1 = 7; v.u1 = 1;
    step(v);
    v = '0; v.md = 1; step(v);
    v = '0; repeat (2) step(v);
    v.dw = 1; repeat (3) step(v);
    v = '0; repeat (N) step(v);
    v = '0; v.md = 1; step(v); step(v);
    v.rst = 1; step(v);
    v.rst = 0; repeat (N + 1) step(v);
    v = '0; repeat (2) step(v);
    for (int i = 0; i < 3000; i++) begin
      v = '0;
      v.rst = ($urandom_range(0, 99) < 2);
      v.r1 = 5'($urandom_range(0, 3));
      v.r2 = 5'($urandom_range(0, 3));
      v.rd = 5'($urandom_range(0, 3));
      v.u1 = 1'($urandom);
      v.u2 = 1'($urandom);
      v.mr = ($urandom_range(0, 99) < 40);
      v.md = ($urandom_range(0, 99) < 6);
      v.br = ($urandom_range(0, 99) < 15);
      v.iw = ($urandom_range(0, 99) < 7);
      v.dw = ($urandom_range(0, 99) < 7);
      step(v);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
